intra_blk_scheduler: RTL and testbench

- Sequences the intraloop datapath over one frame in raster order of BLK x BLK blocks.
- Issues one block address (mbnumber = {row, col}) at a time through a valid/ready handshake.
- Waits for the datapath's completion pulse before issuing the next block, because intra prediction needs reconstructed neighbours; at most one block is in flight.
- Sits between the frame-level control and the intraloop instance.

---
 rtl/intra_blk_scheduler.sv | 135 +++++++++++++
 tb/tb_intra_blk_scheduler.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_blk_scheduler.sv
// Raster-order block issuer for the intraloop datapath, one block in flight.
// Optional stall counter enabled by defining INTRA_SCHED_PERF_EN.
module intra_blk_scheduler #(
  parameter int WIDTH  = 1280,
  parameter int LENGTH = 720,
  parameter int BLK    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        enable,
  output logic        blk_valid,
  input  logic        blk_ready,
  input  logic        blk_done,
  output logic [31:0] mbnumber,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] blk_count
`ifdef INTRA_SCHED_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [15:0] STEP = 16'(BLK);
  localparam logic [15:0] W16  = 16'(WIDTH);
  localparam logic [15:0] LROW = 16'(LENGTH - BLK);
  localparam logic [15:0] LCOL = 16'(WIDTH - BLK);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] row_q, row_d;
  logic [15:0] col_q, col_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic        hs;
  logic        last;
  logic [15:0] col_nxt;

  assign hs      = vld_q && blk_ready;
  assign last    = (row_q == LROW) && (col_q == LCOL);
  assign col_nxt = col_q + STEP;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = ISSUE;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
        end
      end
      ISSUE: begin
        if (hs) state_d = WAIT;
      end
      WAIT: begin
        if (blk_done) begin
          cnt_d = cnt_q + 16'd1;
          if (last) begin
            state_d = DONE;
          end else begin
            state_d = ISSUE;
            if (col_nxt == W16) begin
              col_d = '0;
              row_d = row_q + STEP;
            end else begin
              col_d = col_nxt;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Valid is loaded on entry to ISSUE so a block can issue in its first cycle
    vld_d = (state_d == ISSUE) && enable;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign blk_valid  = vld_q;
  assign mbnumber   = {row_q, col_q};
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign blk_count  = cnt_q;

`ifdef INTRA_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && frame_start) begin
      stall_d = '0;
    end else if (state_q == ISSUE && !hs && stall_q != 32'hFFFF_FFFF) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_intra_blk_scheduler.sv
// Scoreboard bench: 16x8 frames with stalls, pauses, spurious inputs, reset,
// plus a 1280x720 frame with 16-pixel blocks.
module tb_intra_blk_scheduler;

  logic        clk;
  logic        rst_n;

  logic        frame_start, enable, blk_ready, blk_done;
  logic        blk_valid, busy, frame_done;
  logic [31:0] mbnumber;
  logic [15:0] blk_count;

  logic        l_fs, l_en, l_rdy, l_done;
  logic        l_valid, l_busy, l_fd;
  logic [31:0] l_mb;
  logic [15:0] l_cnt;

`ifdef INTRA_SCHED_PERF_EN
  logic [31:0] stall_cycles, l_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_m   = 0;
  int fd_n    = 0;

  logic [31:0] sb_q[$];
  logic [31:0] lq[$];

  intra_blk_scheduler #(.WIDTH(16), .LENGTH(8), .BLK(4)) u_dut (
    .clk         (clk),
    .reset       (rst_n),
    .frame_start (frame_start),
    .enable      (enable),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .blk_done    (blk_done),
    .mbnumber    (mbnumber),
    .busy        (busy),
    .frame_done  (frame_done),
    .blk_count   (blk_count)
`ifdef INTRA_SCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  intra_blk_scheduler #(.WIDTH(1280), .LENGTH(720), .BLK(16)) u_big (
    .clk         (clk),
    .reset       (rst_n),
    .frame_start (l_fs),
    .enable      (l_en),
    .blk_valid   (l_valid),
    .blk_ready   (l_rdy),
    .blk_done    (l_done),
    .mbnumber    (l_mb),
    .busy        (l_busy),
    .frame_done  (l_fd),
    .blk_count   (l_cnt)
`ifdef INTRA_SCHED_PERF_EN
    ,
    .stall_cycles(l_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done) fd_n++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Entered at a negedge just after the DUT moved into ISSUE with enable=1.
  task automatic do_block(input int bp, input int ps, input bit spur,
                          input bit fsm, input bit rst);
    logic [31:0] exp;
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk("issue_valid", {31'd0, blk_valid}, 1);
    chk("issue_mb", mbnumber, exp);
    if (ps > 0) begin
      enable    = 1'b0;
      blk_ready = 1'b0;
      for (int i = 0; i < ps; i++) begin
        @(negedge clk);
        chk("pause_valid", {31'd0, blk_valid}, 0);
        chk("pause_mb", mbnumber, exp);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("resume_valid", {31'd0, blk_valid}, 1);
      chk("resume_mb", mbnumber, exp);
    end
    blk_done = spur;
    if (bp > 0) begin
      blk_ready = 1'b0;
      for (int i = 0; i < bp; i++) begin
        @(negedge clk);
        chk("bp_valid", {31'd0, blk_valid}, 1);
        chk("bp_mb", mbnumber, exp);
        chk("bp_cnt", {16'd0, blk_count}, cnt_m);
      end
    end
    blk_ready = 1'b1;
    @(negedge clk);
    blk_done = 1'b0;
    chk("wait_valid", {31'd0, blk_valid}, 0);
    chk("wait_busy", {31'd0, busy}, 1);
    chk("wait_cnt", {16'd0, blk_count}, cnt_m);
    if (rst) begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", {31'd0, blk_valid}, 0);
      chk("rst_mb", mbnumber, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_fd", {31'd0, frame_done}, 0);
      chk("rst_cnt", {16'd0, blk_count}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    if (fsm) frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    @(negedge clk);
    chk("wait2_valid", {31'd0, blk_valid}, 0);
    blk_done = 1'b1;
    @(negedge clk);
    blk_done = 1'b0;
    cnt_m++;
    chk("done_cnt", {16'd0, blk_count}, cnt_m);
    if (cnt_m < 8) chk("early_fd", {31'd0, frame_done}, 0);
  endtask

  task automatic run_frame(input int bp_i, input int ps_i, input int sp_i,
                           input int fs_i, input int rst_i,
                           input logic [31:0] exp_stall);
    int fd0;
    fd0 = fd_n;
    sb_q.delete();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        sb_q.push_back({16'(r * 4), 16'(c * 4)});
    enable      = 1'b1;
    blk_ready   = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    cnt_m = 0;
    chk("start_busy", {31'd0, busy}, 1);
    chk("start_cnt", {16'd0, blk_count}, 0);
    for (int b = 0; b < 8; b++) begin
      do_block((b == bp_i) ? 5 : 0, (b == ps_i) ? 4 : 0,
               b == sp_i, b == fs_i, b == rst_i);
      if (b == rst_i) return;
    end
    chk("fd_pulse", {31'd0, frame_done}, 1);
    chk("fd_blkcnt", {16'd0, blk_count}, 8);
    chk("fd_mb", mbnumber, 32'h0004_000C);
    chk("sb_empty", sb_q.size(), 0);
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_fd", {31'd0, frame_done}, 0);
    chk("idle_valid", {31'd0, blk_valid}, 0);
    chk("fd_once", fd_n - fd0, 1);
`ifdef INTRA_SCHED_PERF_EN
    chk("stall", stall_cycles, exp_stall);
`endif
  endtask

  initial begin
    logic [31:0] last_mb;
    bit          seen_fd;
    rst_n = 1'b0;
    frame_start = 0; enable = 0; blk_ready = 0; blk_done = 0;
    l_fs = 0; l_en = 0; l_rdy = 0; l_done = 0;
    #23;
    chk("reset_valid", {31'd0, blk_valid}, 0);
    chk("reset_mb", mbnumber, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_fd", {31'd0, frame_done}, 0);
    chk("reset_cnt", {16'd0, blk_count}, 0);
`ifdef INTRA_SCHED_PERF_EN
    chk("reset_stall", stall_cycles, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame(-1, -1, -1, -1, -1, 0);
    run_frame(1, -1, -1, -1, -1, 5);
    run_frame(-1, 2, -1, -1, -1, 5);
    run_frame(3, -1, 3, 5, -1, 5);
    run_frame(-1, -1, -1, -1, 4, 0);
    run_frame(-1, -1, -1, -1, -1, 0);

    for (int r = 0; r < 45; r++)
      for (int c = 0; c < 80; c++)
        lq.push_back({16'(r * 16), 16'(c * 16)});
    l_en = 1; l_rdy = 1; l_fs = 1;
    @(negedge clk);
    l_fs = 0;
    last_mb = '0;
    seen_fd = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (l_fd) begin
        seen_fd = 1;
        break;
      end
      if (l_valid) begin
        if (lq.size() == 0) chk("big_extra_blk", l_mb, 32'hFFFF_FFFF);
        else chk("big_mb", l_mb, lq.pop_front());
        last_mb = l_mb;
      end
      l_done = l_busy && !l_valid;
      @(negedge clk);
    end
    l_done = 0;
    chk("big_timeout", {31'd0, seen_fd}, 1);
    chk("big_last_mb", last_mb, {16'd704, 16'd1264});
    chk("big_fd_mb", l_mb, {16'd704, 16'd1264});
    chk("big_cnt", {16'd0, l_cnt}, 3600);
    chk("big_sb_empty", lq.size(), 0);
`ifdef INTRA_SCHED_PERF_EN
    chk("big_stall", l_stall, 0);
`endif
    @(negedge clk);
    chk("big_idle", {31'd0, l_busy}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
